// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side controller.
// Holds the controller state encoding and PS/2 protocol byte values.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_RESP
    } ps2_state_t;

    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam int         PS2_BITS_TX = 10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // PS/2 frames carry odd parity over the 8 data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 pad plus a falling-edge strobe.
// Ports: clk, reset (sync, active-high), pad (async in),
//        level (synchronised line), fall (1-cycle strobe on 1->0).
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Idle PS/2 lines float high, so reset all stages to 1 to
    // avoid a spurious fall strobe when reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pad;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_controller.sv
// PS/2 bus owner: gates device-to-host reception and runs host-to-device
// command transmission (inhibit, RTS, frame shift, line ACK, response).
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready/cmd_byte
// command handshake; ps2_clock_in/ps2_data_in raw pads; ps2_*_oe
// open-drain pull-downs; read_enable to receiver; rx_ready/rx_valid/
// rx_byte from receiver; resp_valid/resp_byte response; cmd_error on
// abandon; busy when not idle.
module ps2_host_controller #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int BIT_TIMEOUT    = 750000,
    parameter int RESP_TIMEOUT   = 1000000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    output logic       read_enable,
    input  logic       rx_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       resp_valid,
    output logic [7:0] resp_byte,
    output logic       cmd_error,
    output logic       busy
);

    import ps2_pkg::*;

    localparam int TMAX = max3(INHIBIT_CYCLES, BIT_TIMEOUT,
                               RESP_TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = (MAX_RETRIES > 0) ?
                          $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_TIMEOUT - 1);
    localparam logic [TW-1:0] RESP_LAST = TW'(RESP_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [3:0]    STOP_IDX  = 4'(PS2_BITS_TX - 1);

    ps2_state_t    state;
    logic [TW-1:0] timer;
    logic [3:0]    bit_idx;
    logic [RW-1:0] retry_cnt;
    logic [7:0]    cmd_q;
    logic          parity_q;

    logic clk_fall;
    logic clk_level_unused;
    logic data_level;
    logic data_fall_unused;
    logic retry;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .pad   (ps2_clock_in),
        .level (clk_level_unused),
        .fall  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk),
        .reset (reset),
        .pad   (ps2_data_in),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    // Every failure path (bit timeout, line NAK, resend request,
    // receive error, response timeout) funnels into one retry action.
    always_comb begin
        retry = 1'b0;
        case (state)
            SEND:
                retry = !clk_fall && (timer == BIT_LAST);
            ACK:
                retry = clk_fall ? data_level
                                 : (timer == BIT_LAST);
            WAIT_RESP:
                retry = rx_ready ? (!rx_valid ||
                                    rx_byte == PS2_RESEND)
                                 : (timer == RESP_LAST);
            default:
                retry = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            bit_idx      <= '0;
            retry_cnt    <= '0;
            cmd_q        <= '0;
            parity_q     <= 1'b0;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            read_enable  <= 1'b1;
            cmd_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_byte    <= '0;
            cmd_error    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            cmd_error  <= 1'b0;
            if (retry) begin
                ps2_data_oe <= 1'b0;
                timer       <= '0;
                bit_idx     <= '0;
                if (retry_cnt < RETRY_MAX) begin
                    // Same byte again, straight back to inhibit.
                    retry_cnt    <= retry_cnt + 1'b1;
                    state        <= INHIBIT;
                    ps2_clock_oe <= 1'b1;
                    read_enable  <= 1'b0;
                end else begin
                    retry_cnt    <= '0;
                    state        <= IDLE;
                    ps2_clock_oe <= 1'b0;
                    read_enable  <= 1'b1;
                    cmd_ready    <= 1'b1;
                    busy         <= 1'b0;
                    cmd_error    <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        // A byte arriving from the device wins over
                        // a new command in the same cycle.
                        if (cmd_valid && cmd_ready && !rx_ready) begin
                            cmd_q        <= cmd_byte;
                            parity_q     <= odd_parity(cmd_byte);
                            retry_cnt    <= '0;
                            timer        <= '0;
                            state        <= INHIBIT;
                            ps2_clock_oe <= 1'b1;
                            read_enable  <= 1'b0;
                            cmd_ready    <= 1'b0;
                            busy         <= 1'b1;
                        end
                    end
                    INHIBIT: begin
                        if (timer == INH_LAST) begin
                            timer       <= '0;
                            state       <= RTS;
                            ps2_data_oe <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    RTS: begin
                        // Start bit already on data; free the clock
                        // so the device begins clocking the frame.
                        ps2_clock_oe <= 1'b0;
                        bit_idx      <= '0;
                        timer        <= '0;
                        state        <= SEND;
                    end
                    SEND: begin
                        if (clk_fall) begin
                            timer   <= '0;
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx < 4'd8) begin
                                ps2_data_oe <= ~cmd_q[bit_idx[2:0]];
                            end else if (bit_idx != STOP_IDX) begin
                                ps2_data_oe <= ~parity_q;
                            end else begin
                                ps2_data_oe <= 1'b0;
                                state       <= ACK;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ACK: begin
                        // A high data line here is caught by retry.
                        if (clk_fall) begin
                            timer       <= '0;
                            read_enable <= 1'b1;
                            state       <= WAIT_RESP;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    WAIT_RESP: begin
                        if (rx_ready) begin
                            resp_byte  <= rx_byte;
                            resp_valid <= 1'b1;
                            retry_cnt  <= '0;
                            state      <= IDLE;
                            cmd_ready  <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_controller.sv
// Randomised scoreboard bench for ps2_host_controller with a PS/2
// device model on the pads and a plan-level model of the retry rules.
module tb_ps2_host_controller;

    localparam int INH  = 200;
    localparam int BTO  = 100;
    localparam int RTO  = 300;
    localparam int MAXR = 2;
    localparam int HALF = 20;

    typedef enum int {
        B_OK, B_NAKLINE, B_FE, B_RXERR, B_STALL, B_SILENT, B_RESET
    } beh_e;

    typedef struct {
        beh_e       beh;
        logic [7:0] resp;
    } attempt_t;

    typedef struct {
        bit         is_err;
        logic [7:0] val;
    } result_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       rx_ready = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;

    logic       cmd_ready;
    logic       ps2_clock_in;
    logic       ps2_data_in;
    logic       ps2_clock_oe;
    logic       ps2_data_oe;
    logic       read_enable;
    logic       resp_valid;
    logic [7:0] resp_byte;
    logic       cmd_error;
    logic       busy;

    // Open-drain bus: either side may pull a line low.
    assign ps2_clock_in = dev_clk & ~ps2_clock_oe;
    assign ps2_data_in  = dev_data & ~ps2_data_oe;

    ps2_host_controller #(
        .INHIBIT_CYCLES (INH),
        .BIT_TIMEOUT    (BTO),
        .RESP_TIMEOUT   (RTO),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_byte     (cmd_byte),
        .ps2_clock_in (ps2_clock_in),
        .ps2_data_in  (ps2_data_in),
        .ps2_clock_oe (ps2_clock_oe),
        .ps2_data_oe  (ps2_data_oe),
        .read_enable  (read_enable),
        .rx_ready     (rx_ready),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .resp_valid   (resp_valid),
        .resp_byte    (resp_byte),
        .cmd_error    (cmd_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int inhibit_phases = 0;
    int inh_run = 0;

    attempt_t   att_q[$];
    result_t    exp_q[$];
    logic [7:0] cur_cmd = 8'h00;

    attempt_t    dev_a;
    logic [10:0] dev_got;
    logic [10:0] dev_exp;
    int          dev_fall;
    int          dev_w;
    int          dev_dt;
    result_t     mon_e;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected wire frame: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Outcome of a command given what the device does on each try.
    function automatic int plan(input attempt_t a[3],
                                output result_t r, output bit has_r);
        r.is_err = 1'b1;
        r.val    = 8'h00;
        has_r    = 1'b1;
        if (a[0].beh == B_RESET) begin
            has_r = 1'b0;
            return 1;
        end
        for (int i = 0; i <= MAXR; i++) begin
            if (a[i].beh == B_OK) begin
                r.is_err = 1'b0;
                r.val    = a[i].resp;
                return i + 1;
            end
        end
        return MAXR + 1;
    endfunction

    function automatic attempt_t mk(input beh_e b, input logic [7:0] v);
        attempt_t t;
        t.beh  = b;
        t.resp = v;
        return t;
    endfunction

    function automatic attempt_t rand_att();
        int r;
        logic [7:0] v;
        r = $urandom_range(0, 9);
        v = 8'($urandom_range(0, 255));
        if (v == 8'hFE || r < 2) v = 8'hFA;
        if (r < 5) return mk(B_OK, v);
        case (r)
            5: return mk(B_NAKLINE, v);
            6: return mk(B_FE, v);
            7: return mk(B_RXERR, v);
            8: return mk(B_STALL, v);
            default: return mk(B_SILENT, v);
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Inhibit phases: clock held low before the data line drops.
    initial forever begin
        @(negedge clk);
        if (ps2_clock_oe && !ps2_data_oe) begin
            inh_run++;
        end else begin
            if (ps2_clock_oe && ps2_data_oe && inh_run > 0) begin
                chk("inhibit_len", inh_run, INH);
                inhibit_phases++;
            end
            inh_run = 0;
        end
    end

    // Scoreboard monitor.
    initial forever begin
        @(negedge clk);
        if (resp_valid || cmd_error) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output resp_valid=%0b cmd_error=%0b byte=%0h required=none",
                         resp_valid, cmd_error, resp_byte);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result_error", cmd_error, mon_e.is_err);
                chk("result_valid", resp_valid, !mon_e.is_err);
                if (!mon_e.is_err) chk("resp_byte", resp_byte, mon_e.val);
                chk("pulse_in_idle", {busy, cmd_ready}, 2'b01);
            end
        end
    end

    task automatic rx_pulse(input logic v, input logic [7:0] b);
        rx_ready = 1'b1;
        rx_valid = v;
        rx_byte  = b;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_valid = 1'b0;
    endtask

    // PS/2 device model: reacts to each request-to-send.
    initial forever begin
        @(negedge clk);
        if (!reset && !ps2_clock_oe && ps2_data_oe) begin
            if (att_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_frame actual=1 required=0");
                dev_a = mk(B_NAKLINE, 8'h00);
            end else begin
                dev_a = att_q.pop_front();
            end
            dev_exp = frame_of(cur_cmd);
            dev_got = '1;
            repeat (8) @(negedge clk);
            dev_got[0] = ps2_data_in;
            for (int i = 1; i <= 10; i++) begin
                dev_clk  = 1'b0;
                dev_fall = cyc;
                repeat (HALF) @(negedge clk);
                if (dev_a.beh == B_RESET && i == 4) begin
                    reset = 1'b1;
                    @(negedge clk);
                    chk("rst_clock_oe", ps2_clock_oe, 0);
                    chk("rst_data_oe", ps2_data_oe, 0);
                    chk("rst_read_en", read_enable, 1);
                    chk("rst_cmd_ready", cmd_ready, 1);
                    chk("rst_busy", busy, 0);
                    reset   = 1'b0;
                    dev_clk = 1'b1;
                    break;
                end
                dev_clk = 1'b1;
                repeat (2) @(negedge clk);
                dev_got[i] = ps2_data_in;
                if (dev_a.beh == B_STALL && i == 4) break;
                repeat (HALF - 2) @(negedge clk);
            end
            if (dev_a.beh == B_STALL) begin
                dev_w = 0;
                while (!ps2_clock_oe && dev_w < 400) begin
                    @(negedge clk);
                    dev_w++;
                end
                // Allow the synchroniser delay on top of the timeout.
                dev_dt = cyc - dev_fall;
                chk("stall_release_time",
                    (dev_dt >= BTO && dev_dt <= BTO + 5), 1);
                chk("stall_data_oe", ps2_data_oe, 0);
                chk("stall_partial_frame", dev_got[4:0], dev_exp[4:0]);
            end else if (dev_a.beh != B_RESET) begin
                chk("frame_bits", dev_got, dev_exp);
                if (dev_a.beh != B_NAKLINE) dev_data = 1'b0;
                repeat (10) @(negedge clk);
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clk);
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                if (dev_a.beh != B_NAKLINE)
                    chk("wait_resp_read_en", read_enable, 1);
                repeat (30) @(negedge clk);
                case (dev_a.beh)
                    B_OK:    rx_pulse(1'b1, dev_a.resp);
                    B_FE:    rx_pulse(1'b1, 8'hFE);
                    B_RXERR: rx_pulse(1'b0, dev_a.resp);
                    default: ;
                endcase
            end
        end
    end

    task automatic run_cmd(input logic [7:0] b, input attempt_t a[3]);
        int      n;
        int      ph0;
        int      waited;
        result_t r;
        bit      has_r;
        n = plan(a, r, has_r);
        for (int i = 0; i < n; i++) att_q.push_back(a[i]);
        if (has_r) exp_q.push_back(r);
        cur_cmd = b;
        ph0 = inhibit_phases;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_byte  = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("accept_busy", busy, 1);
        chk("accept_cmd_ready", cmd_ready, 0);
        waited = 0;
        while (busy && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        chk("cmd_done_in_time", waited < 20000, 1);
        repeat (60) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("attempts_used", att_q.size(), 0);
        chk("inhibit_phases", inhibit_phases - ph0, n);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_read_en", read_enable, 1);
        exp_q.delete();
        att_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        attempt_t a[3];
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_clock_oe", ps2_clock_oe, 0);
        chk("reset_data_oe", ps2_data_oe, 0);
        chk("reset_read_en", read_enable, 1);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_byte", resp_byte, 0);
        chk("reset_cmd_error", cmd_error, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        a[0] = mk(B_OK, 8'hFA);
        a[1] = mk(B_OK, 8'hFA);
        a[2] = mk(B_OK, 8'hFA);
        run_cmd(8'hF4, a);

        a[0] = mk(B_NAKLINE, 8'hFA);
        a[1] = mk(B_NAKLINE, 8'hFA);
        a[2] = mk(B_OK, 8'hFA);
        run_cmd(8'hF4, a);

        a[0] = mk(B_FE, 8'hFA);
        a[1] = mk(B_FE, 8'hFA);
        a[2] = mk(B_FE, 8'hFA);
        run_cmd(8'hFF, a);

        a[0] = mk(B_STALL, 8'hFA);
        a[1] = mk(B_OK, 8'hFA);
        a[2] = mk(B_OK, 8'hFA);
        run_cmd(8'hE0, a);

        a[0] = mk(B_RXERR, 8'h00);
        a[1] = mk(B_SILENT, 8'h00);
        a[2] = mk(B_OK, 8'hAA);
        run_cmd(8'hED, a);

        // Unsolicited byte while idle, with a colliding command.
        @(negedge clk);
        rx_ready  = 1'b1;
        rx_valid  = 1'b1;
        rx_byte   = 8'h1C;
        cmd_valid = 1'b1;
        cmd_byte  = 8'hF2;
        @(negedge clk);
        rx_ready  = 1'b0;
        rx_valid  = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("unsol_busy", busy, 0);
        chk("unsol_cmd_ready", cmd_ready, 1);
        chk("unsol_read_en", read_enable, 1);
        repeat (20) @(negedge clk);
        chk("unsol_clock_oe", ps2_clock_oe, 0);
        chk("unsol_busy_later", busy, 0);

        a[0] = mk(B_RESET, 8'h00);
        a[1] = mk(B_OK, 8'hFA);
        a[2] = mk(B_OK, 8'hFA);
        run_cmd(8'h5A, a);

        for (int k = 0; k < 10; k++) begin
            a[0] = rand_att();
            a[1] = rand_att();
            a[2] = rand_att();
            run_cmd(8'($urandom_range(0, 255)), a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
